hamming_decode_ctrl: RTL and testbench
======================================

Name: hamming_decode_ctrl

Overview:
Sequencing controller for the serial Hamming(7,4) decoder datapath.
- Steps the receive shift register through 7 codeword bits.
- Strobes syndrome capture and the single-bit correction.
- Drives the 4-cycle data shift-out with backpressure, then signals completion.
- Replaces the free-running shift counter with a start/done-handshaked FSM so frames can be back-to-back or stalled.

Parameters:
CODE_LEN, 7, codeword bits accepted per frame
DATA_LEN, 4, data bits shifted out per frame
CNT_W, 3, beat counter width; must satisfy 2**CNT_W >= CODE_LEN

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a frame; sampled only in IDLE
in_valid  input  1  serial codeword bit present on datapath input this cycle
rx_shift  output  1  shift-enable to receive register
syn_load  output  1  capture syndrome into datapath register
syn_nonzero  input  1  datapath syndrome != 0 (valid the cycle after syn_load)
corr_en  output  1  apply bit-flip at syndrome position
tx_shift  output  1  shift-enable to data output register; one data bit accepted
out_ready  input  1  downstream accepts a data bit this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at frame end
err_flag  output  1  frame had nonzero syndrome; sticky until next accepted start

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, err_flag=0, done=0. All strobes are 0 during reset and in the first cycle after release.
- States: IDLE, RX, CHECK, CORR, TX, DONE. State and cnt are registered.
- Strobes are decoded from state: rx_shift, syn_load, corr_en and tx_shift are combinational in state and inputs; done is combinational in state.
- IDLE:
  - start=1 -> RX, cnt<=0, err_flag<=0.
  - start=0 -> stay.
- RX:
  - rx_shift = in_valid.
  - Each cycle with in_valid=1: cnt<=cnt+1.
  - in_valid=1 and cnt==CODE_LEN-1 -> CHECK, cnt<=0.
  - in_valid=0 stalls RX indefinitely; no timeout.
- CHECK: syn_load=1 for exactly one cycle -> CORR.
- CORR:
  - corr_en = syn_nonzero.
  - err_flag <= syn_nonzero.
  - Go to TX, cnt<=0.
  - Exactly one cycle.
- TX:
  - tx_shift = out_ready.
  - Each cycle with out_ready=1: cnt<=cnt+1.
  - out_ready=1 and cnt==DATA_LEN-1 -> DONE.
  - out_ready=0 holds state and cnt.
- DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE, including in DONE. Minimum frame-to-frame spacing is DONE followed by IDLE.
- Latency with in_valid=out_ready=1 and start at cycle 0:
  - rx_shift cycles 1-7
  - syn_load cycle 8
  - corr_en cycle 9
  - tx_shift cycles 10-13
  - done cycle 14
- Counter never wraps; the terminal compare gates all transitions. cnt holds at 0 in IDLE, CHECK, CORR and DONE.
- Reset asserted mid-frame: immediate return to IDLE and all strobes 0. The partial frame is discarded; no done pulse.
- Simultaneous start and reset: reset wins.

Optional Feature:
HAMMING_ERR_COUNT_EN
- Defined:
  - Adds output err_count[7:0].
  - Increments in CORR when syn_nonzero=1.
  - Saturates at 255.
  - Cleared only by reset_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package hamming_ctrl_pkg holds:
  - state enum type with the 6 states.
  - CODE_LEN, DATA_LEN and CNT_W default constants.
  - ERR_CNT_W=8.
- One sub-module, hamming_beat_cnt:
  - Inputs: clear, enable, terminal value.
  - Outputs: count and terminal-reached.
  - Instantiated once; shared by RX and TX.

Test Plan:
- Reset release, start pulse at cycle 0, in_valid=out_ready=1, syn_nonzero=0 -> rx_shift high exactly 7 cycles (1-7), syn_load at 8, corr_en low at 9, tx_shift 10-13, done at 14, err_flag=0, busy 1-14.
- Same frame with syn_nonzero=1 during CORR -> corr_en=1 at cycle 9; err_flag=1 from cycle 10 until next accepted start, then cleared.
- in_valid toggled 1,0,1,0... during RX -> exactly 7 rx_shift pulses, only on in_valid=1 cycles; CHECK entered the cycle after the 7th.
- out_ready=0 for 5 cycles after second data bit -> state held, no tx_shift; 4 tx_shift total; done one cycle after the 4th.
- reset_n low at cycle 5 mid-RX -> outputs 0 asynchronously; after release, start is accepted and a full frame completes normally.
- start held high continuously, plus 3 frames with syn_nonzero=1 under HAMMING_ERR_COUNT_EN -> start ignored in busy states, new frame begins the cycle after DONE→IDLE; err_count=3. With 300 error frames, err_count stays at 255.

Source files
------------

// File: rtl/hamming_ctrl_pkg.sv
// Shared types and default sizing for the serial Hamming(7,4) decode controller.
// Holds the FSM state encoding plus frame-length and error-counter widths.
package hamming_ctrl_pkg;

    localparam int CODE_LEN_DFLT = 7;
    localparam int DATA_LEN_DFLT = 4;
    localparam int CNT_W_DFLT    = 3;
    localparam int ERR_CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX    = 3'd1,
        S_CHECK = 3'd2,
        S_CORR  = 3'd3,
        S_TX    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/hamming_beat_cnt.sv
// Beat counter shared by the receive and transmit phases; wraps to 0 on the terminal beat.
// Latency: count updates one cycle after enable; at_term is combinational.
// Backpressure: enable low holds the count; clear forces 0 and overrides enable.
module hamming_beat_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    assign at_term = (count == term);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_term ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/hamming_decode_ctrl.sv
// Start/done handshaked sequencer for the serial Hamming(7,4) decoder; HAMMING_ERR_COUNT_EN adds err_count.
// Latency: start at cycle 0 -> rx 1-7, syn_load 8, corr 9, tx 10-13, done 14 when unstalled.
// Backpressure: in_valid low stalls RX, out_ready low stalls TX; start is ignored while busy.
module hamming_decode_ctrl
    import hamming_ctrl_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DFLT,
    parameter int DATA_LEN = DATA_LEN_DFLT,
    parameter int CNT_W    = CNT_W_DFLT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic in_valid,
    output logic rx_shift,
    output logic syn_load,
    input  logic syn_nonzero,
    output logic corr_en,
    output logic tx_shift,
    input  logic out_ready,
    output logic busy,
    output logic done,
`ifdef HAMMING_ERR_COUNT_EN
    output logic [ERR_CNT_W-1:0] err_count,
`endif
    output logic err_flag
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_at_term;
    logic             cnt_clear;

    localparam logic [CNT_W-1:0] RX_TERM = CNT_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0] TX_TERM = CNT_W'(DATA_LEN - 1);

    assign rx_shift = (state == S_RX) && in_valid;
    assign syn_load = (state == S_CHECK);
    assign corr_en  = (state == S_CORR) && syn_nonzero;
    assign tx_shift = (state == S_TX) && out_ready;
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE);

    // Counter only runs in the two shifting phases, so it sits at 0 everywhere else.
    assign cnt_clear = (state != S_RX) && (state != S_TX);
    assign cnt_term  = (state == S_RX) ? RX_TERM : TX_TERM;

    hamming_beat_cnt #(.CNT_W(CNT_W)) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (rx_shift || tx_shift),
        .term    (cnt_term),
        .count   (cnt),
        .at_term (cnt_at_term)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RX;
            S_RX:    if (in_valid && cnt_at_term) state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_CORR;
            S_CORR:  state_nxt = S_TX;
            S_TX:    if (out_ready && cnt_at_term) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            err_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                err_flag <= 1'b0;
            end else if (state == S_CORR) begin
                err_flag <= syn_nonzero;
            end
        end
    end

`ifdef HAMMING_ERR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (state == S_CORR && syn_nonzero && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_hamming_decode_ctrl.sv
// Directed bench for hamming_decode_ctrl; err_count checks run when HAMMING_ERR_COUNT_EN is defined.
module tb_hamming_decode_ctrl;

    logic clk = 1'b0;
    logic reset_n, start, in_valid, syn_nonzero, out_ready;
    logic rx_shift, syn_load, corr_en, tx_shift, busy, done, err_flag;
`ifdef HAMMING_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hamming_decode_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .rx_shift    (rx_shift),
        .syn_load    (syn_load),
        .syn_nonzero (syn_nonzero),
        .corr_en     (corr_en),
        .tx_shift    (tx_shift),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
`ifdef HAMMING_ERR_COUNT_EN
        .err_count   (err_count),
`endif
        .err_flag    (err_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: busy rx_shift syn_load corr_en tx_shift done err_flag
    function automatic logic [31:0] outs();
        return {25'd0, busy, rx_shift, syn_load, corr_en, tx_shift, done, err_flag};
    endfunction

    function automatic logic [31:0] vec(input logic b, r, s, c, t, d, e);
        return {25'd0, b, r, s, c, t, d, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unstalled frame, start at c=0, checked cycle by cycle through the IDLE at c=15.
    task automatic nominal_frame(input string name, input logic syn, input logic prev_err);
        logic e;
        for (int c = 0; c <= 15; c++) begin
            start       = (c == 0);
            in_valid    = 1'b1;
            out_ready   = 1'b1;
            syn_nonzero = syn;
            #1;
            e = (c == 0) ? prev_err : ((c >= 10) ? syn : 1'b0);
            chk($sformatf("%s_c%0d", name, c), outs(),
                vec(c >= 1 && c <= 14, c >= 1 && c <= 7, c == 8, c == 9 && syn,
                    c >= 10 && c <= 13, c == 14, e));
            tick();
        end
    endtask

    initial begin
        int pulses;
        reset_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; syn_nonzero = 1'b1;
        #1;
        chk("reset_outs", outs(), 32'd0);
        tick(); tick();
        chk("reset_outs_held", outs(), 32'd0);
        reset_n = 1'b1; start = 1'b0;
        #1;
        chk("post_release_outs", outs(), 32'd0);
        tick();

        nominal_frame("nom", 1'b0, 1'b0);
        nominal_frame("err", 1'b1, 1'b0);

        // in_valid alternates starting high at c=1; err_flag from prior frame clears at c=1
        pulses = 0;
        for (int c = 0; c <= 21; c++) begin
            start       = (c == 0);
            in_valid    = (c >= 1 && c <= 13) ? (c % 2 == 1) : 1'b1;
            out_ready   = 1'b1;
            syn_nonzero = 1'b0;
            #1;
            if (rx_shift) pulses++;
            chk($sformatf("tog_c%0d", c), outs(),
                vec(c >= 1 && c <= 20, c >= 1 && c <= 13 && (c % 2 == 1), c == 14, 1'b0,
                    c >= 16 && c <= 19, c == 20, c == 0));
            tick();
        end
        chk("tog_rx_pulses", pulses, 7);

        // out_ready low for 5 cycles after the second data bit
        pulses = 0;
        for (int c = 0; c <= 20; c++) begin
            start       = (c == 0);
            in_valid    = 1'b1;
            out_ready   = !(c >= 12 && c <= 16);
            syn_nonzero = 1'b0;
            #1;
            if (tx_shift) pulses++;
            chk($sformatf("bp_c%0d", c), outs(),
                vec(c >= 1 && c <= 19, c >= 1 && c <= 7, c == 8, 1'b0,
                    c == 10 || c == 11 || c == 17 || c == 18, c == 19, 1'b0));
            tick();
        end
        chk("bp_tx_pulses", pulses, 4);

        // Reset mid-RX at c=5
        for (int c = 0; c <= 4; c++) begin
            start = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
            tick();
        end
        #1;
        chk("mid_rx_before_reset", outs(), vec(1, 1, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        chk("mid_rx_async_reset", outs(), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mid_rx_after_release", outs(), 32'd0);
        tick();
        chk("mid_rx_no_done", outs(), 32'd0);
        nominal_frame("rst_recover", 1'b0, 1'b0);

        // start held high: frames back to back with one IDLE between them
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c <= 14; c++) begin
                start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; syn_nonzero = 1'b1;
                #1;
                chk($sformatf("hold_f%0d_c%0d", f, c), {29'd0, busy, rx_shift, done},
                    {29'd0, c != 0, c >= 1 && c <= 7, c == 14});
                tick();
            end
        end
        start = 1'b0;
        #1;
        chk("hold_idle_after", outs(), vec(0, 0, 0, 0, 0, 0, 1));
`ifdef HAMMING_ERR_COUNT_EN
        chk("err_count_3", err_count, 8'd3);
        start = 1'b1;
        repeat (297 * 15) tick();
        start = 1'b0;
        #1;
        chk("sat_idle", busy, 1'b0);
        chk("err_count_sat", err_count, 8'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
